uart_rx_frontend: RTL and testbench

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

---
 rtl/uart_rx_frontend.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// UART receive front end: synchronizer, oversampled majority-vote framer,
// break detection and a 2-entry output FIFO with sticky overrun.
module uart_rx_frontend #(
   parameter int SYNC_STAGES = 2,
   parameter int OVERSAMPLE  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       sample_tick,
   input  logic       stop_bits,
   input  logic       out_ready,
   input  logic       overrun_clear,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_framing_error,
   output logic       overrun,
   output logic       break_detect,
   output logic       busy
);

   localparam int CW  = $clog2(OVERSAMPLE);
   localparam int MID = OVERSAMPLE / 2 - 1;
   localparam logic [CW-1:0] PH_A   = CW'(MID - 1);
   localparam logic [CW-1:0] PH_B   = CW'(MID);
   localparam logic [CW-1:0] PH_C   = CW'(MID + 1);
   localparam logic [CW-1:0] PH_END = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP1, STOP2, BRK_WAIT
   } state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   rxs;
   logic                   hist;

   assign rxs = sync[SYNC_STAGES-1];

   // history follows the tick rate so an edge between ticks is still seen
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync <= '1;
         hist <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], rxd};
         if (sample_tick) hist <= rxs;
      end
   end

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          s_a;
   logic          s_b;
   logic          stop_lat;
   logic          stop1_val;
   logic          push;
   logic [8:0]    push_word;
   logic          maj;
   logic          at_c;
   logic          at_end;

   assign maj    = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
   assign at_c   = sample_tick && (cnt == PH_C);
   assign at_end = sample_tick && (cnt == PH_END);
   assign busy   = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         shreg        <= '0;
         s_a          <= 1'b0;
         s_b          <= 1'b0;
         stop_lat     <= 1'b0;
         stop1_val    <= 1'b0;
         push         <= 1'b0;
         push_word    <= '0;
         break_detect <= 1'b0;
      end else begin
         push         <= 1'b0;
         break_detect <= 1'b0;
         if (sample_tick && state != IDLE) begin
            cnt <= (cnt == PH_END) ? '0 : cnt + 1'b1;
            if (cnt == PH_A) s_a <= rxs;
            if (cnt == PH_B) s_b <= rxs;
         end
         case (state)
            IDLE:
               if (sample_tick && !rxs && hist) begin
                  state    <= START;
                  cnt      <= '0;
                  stop_lat <= stop_bits;
               end
            START:
               if (at_c && maj) begin
                  state <= IDLE;
               end else if (at_end) begin
                  state   <= DATA;
                  bit_idx <= '0;
               end
            DATA: begin
               if (at_c) shreg <= {maj, shreg[7:1]};
               if (at_end) begin
                  if (bit_idx == 3'd7) state <= STOP1;
                  bit_idx <= bit_idx + 3'd1;
               end
            end
            STOP1:
               if (at_c) begin
                  if (shreg == 8'h00 && !maj) begin
                     break_detect <= 1'b1;
                     state        <= BRK_WAIT;
                  end else if (!stop_lat) begin
                     push      <= 1'b1;
                     push_word <= {~maj, shreg};
                     state     <= IDLE;
                  end else begin
                     stop1_val <= maj;
                  end
               end else if (at_end) begin
                  state <= STOP2;
               end
            STOP2:
               if (at_c) begin
                  push      <= 1'b1;
                  push_word <= {~(stop1_val & maj), shreg};
                  state     <= IDLE;
               end
            BRK_WAIT:
               if (sample_tick && rxs) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   logic [8:0] mem [2];
   logic       rd_ptr;
   logic       wr_ptr;
   logic [1:0] count;
   logic       pop;
   logic       full;
   logic       wr;

   assign out_valid         = (count != 2'd0);
   assign full              = (count == 2'd2);
   assign pop               = out_valid & out_ready;
   assign wr                = push & (~full | pop);
   assign out_data          = out_valid ? mem[rd_ptr][7:0] : 8'h00;
   assign out_framing_error = out_valid ? mem[rd_ptr][8] : 1'b0;

   // when full, wr_ptr == rd_ptr: a simultaneous pop frees the slot written
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem[0]  <= '0;
         mem[1]  <= '0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= push_word;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         unique case ({wr, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         overrun <= (push & full & ~pop) | (overrun & ~overrun_clear);
      end
   end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend: frames are built from bytes,
// expected {framing_error, data} words are queued and popped by a monitor.
module tb_uart_rx_frontend;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rxd = 1'b1;
   logic       sample_tick = 1'b0;
   logic       stop_bits = 1'b0;
   logic       out_ready = 1'b1;
   logic       overrun_clear = 1'b0;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_framing_error;
   logic       overrun;
   logic       break_detect;
   logic       busy;

   always #5 clk = ~clk;

   uart_rx_frontend #(.SYNC_STAGES(2), .OVERSAMPLE(16)) dut (
      .clk               (clk),
      .reset             (reset),
      .rxd               (rxd),
      .sample_tick       (sample_tick),
      .stop_bits         (stop_bits),
      .out_ready         (out_ready),
      .overrun_clear     (overrun_clear),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_framing_error (out_framing_error),
      .overrun           (overrun),
      .break_detect      (break_detect),
      .busy              (busy)
   );

   int         errors = 0;
   int         checks = 0;
   int         brk_seen = 0;
   int         brk_exp = 0;
   logic       ovr_exp = 1'b0;
   logic [8:0] exp_q [$];
   logic [8:0] e;

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // monitor: inputs change #1 after posedge, so negedge sees the handshake
   always @(negedge clk) begin
      if (!reset) begin
         if (break_detect) brk_seen++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: got %0h expected none",
                        {out_framing_error, out_data});
            end else begin
               e = exp_q.pop_front();
               chk("scoreboard", {23'd0, out_framing_error, out_data}, {23'd0, e});
            end
         end
      end
   end

   task automatic tk(int n);
      repeat (n) begin
         @(posedge clk);
         #1 sample_tick = 1'b1;
         @(posedge clk);
         #1 sample_tick = 1'b0;
      end
   endtask

   task automatic line_bit(logic v);
      rxd = v;
      tk(16);
   endtask

   // reference model: break, drop on full, or queue {fe, data}
   task automatic send(logic [7:0] d, logic sb, logic s1, logic s2);
      stop_bits = sb;
      if (d == 8'h00 && !s1)
         brk_exp++;
      else if (!out_ready && exp_q.size() >= 2)
         ovr_exp = 1'b1;
      else
         exp_q.push_back({sb ? ~(s1 & s2) : ~s1, d});
      line_bit(1'b0);
      for (int i = 0; i < 8; i++) line_bit(d[i]);
      line_bit(s1);
      if (sb) line_bit(s2);
      rxd = 1'b1;
      tk(4 + int'($urandom_range(0, 6)));
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_valid"}, {31'd0, out_valid}, 0);
      chk({tag, "_data"}, {24'd0, out_data}, 0);
      chk({tag, "_fe"}, {31'd0, out_framing_error}, 0);
      chk({tag, "_overrun"}, {31'd0, overrun}, 0);
      chk({tag, "_break"}, {31'd0, break_detect}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      logic       sb;
      logic       s1;
      logic       s2;

      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      reset = 1'b0;
      tk(4);

      send(8'hA5, 1'b0, 1'b1, 1'b1);
      chk("a5_busy", {31'd0, busy}, 0);
      chk("a5_drained", exp_q.size(), 0);

      rxd = 1'b0;
      tk(4);
      rxd = 1'b1;
      tk(16);
      chk("glitch_busy", {31'd0, busy}, 0);
      chk("glitch_valid", {31'd0, out_valid}, 0);

      send(8'h3C, 1'b0, 1'b0, 1'b1);
      send(8'h11, 1'b0, 1'b1, 1'b1);
      chk("fe_drained", exp_q.size(), 0);

      rxd = 1'b0;
      tk(320);
      brk_exp++;
      rxd = 1'b1;
      tk(20);
      chk("break_count", brk_seen, brk_exp);
      chk("break_busy", {31'd0, busy}, 0);
      send(8'h55, 1'b0, 1'b1, 1'b1);

      out_ready = 1'b0;
      send(8'h01, 1'b0, 1'b1, 1'b1);
      send(8'h02, 1'b0, 1'b1, 1'b1);
      send(8'h03, 1'b0, 1'b1, 1'b1);
      chk("overrun_set", {31'd0, overrun}, {31'd0, ovr_exp});
      chk("full_valid", {31'd0, out_valid}, 1);
      chk("full_head", {24'd0, out_data}, 32'h01);
      out_ready = 1'b1;
      tk(4);
      chk("ovr_drained", exp_q.size(), 0);
      chk("overrun_sticky", {31'd0, overrun}, 1);
      overrun_clear = 1'b1;
      @(posedge clk);
      #1 overrun_clear = 1'b0;
      chk("overrun_clear", {31'd0, overrun}, 0);

      send(8'hF0, 1'b1, 1'b1, 1'b0);
      send(8'hF0, 1'b1, 1'b1, 1'b1);
      send(8'h6B, 1'b1, 1'b0, 1'b1);
      send(8'h00, 1'b0, 1'b0, 1'b1);
      send(8'h00, 1'b0, 1'b1, 1'b1);

      for (int n = 0; n < 12; n++) begin
         d  = 8'($urandom);
         sb = 1'($urandom);
         s1 = ($urandom_range(0, 3) != 0);
         s2 = ($urandom_range(0, 3) != 0);
         send(d, sb, s1, s2);
      end
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_breaks", brk_seen, brk_exp);

      stop_bits = 1'b0;
      rxd = 1'b0;
      tk(16);
      rxd = 1'b1;
      tk(16);
      rxd = 1'b0;
      tk(16);
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("midreset");
      rxd = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      tk(40);
      chk("post_reset_valid", {31'd0, out_valid}, 0);
      chk("post_reset_busy", {31'd0, busy}, 0);
      send(8'h9A, 1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      chk("final_queue", exp_q.size(), 0);
      chk("final_breaks", brk_seen, brk_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
